mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 16 +
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder_mem_array.sv | 31 +++
 rtl/mem_responder.sv | 115 +++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// riscv_mem_pkg: shared widths and the responder state type.
//   WORD_W     - data word width (64)
//   ADDR_W     - byte address width (64)
//   memState_t - responder FSM states
package riscv_mem_pkg;

    localparam int WORD_W = 64;
    localparam int ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memState_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: processor <-> memory responder request/response bundle.
//   MemRead, memWrite - request strobes (master -> slave)
//   memadr            - byte address (master -> slave)
//   writedata         - store data (master -> slave)
//   ReadData          - load data (slave -> master)
//   memReady          - one-cycle completion pulse (slave -> master)
//   memErr            - error qualifier for memReady (slave -> master)
interface mem_responder_if;
    import riscv_mem_pkg::*;

    logic              MemRead;
    logic              memWrite;
    logic [ADDR_W-1:0] memadr;
    logic [WORD_W-1:0] writedata;
    logic [WORD_W-1:0] ReadData;
    logic              memReady;
    logic              memErr;

    modport master (
        output MemRead, memWrite, memadr, writedata,
        input  ReadData, memReady, memErr
    );

    modport slave (
        input  MemRead, memWrite, memadr, writedata,
        output ReadData, memReady, memErr
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array: single-port word storage, synchronous write, asynchronous read.
// Contents are never reset.
//   clk       - clock
//   writeEn   - write strobe, word written on rising edge
//   addr      - word index (shared by read and write)
//   writeData - word to store
//   readWord  - word currently at addr
module mem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              writeEn,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] writeData,
    output logic [WORD_W-1:0] readWord
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[addr] <= writeData;
        end
    end

    assign readWord = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder with address/request error
// detection. One transaction at a time; requests outside IDLE are ignored.
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-high reset
//   bus   - mem_responder_if.slave (requests in, ReadData/memReady/memErr out)
//
// state | meaning
// IDLE  | waiting; a request on the next edge is accepted
// BUSY  | latency countdown; access executes when the counter reaches 0
// DONE  | memReady (and memErr if rejected) high for this one cycle
module mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    memState_t         state;
    logic [CNT_W-1:0]  count;
    logic              isWrite;
    logic              isErr;
    logic [IDX_W-1:0]  wordIdx;
    logic [WORD_W-1:0] writeWord;
    logic [WORD_W-1:0] readDataQ;
    logic              readyQ;
    logic              errQ;

    logic              misaligned;
    logic              outOfRange;
    logic              reqErr;
    logic              execNow;
    logic              arrayWriteEn;
    logic [WORD_W-1:0] arrayWord;

    // Both strobes together is rejected like a bad address.
    assign misaligned = |bus.memadr[2:0];
    assign outOfRange = bus.memadr[ADDR_W-1:3] >= (ADDR_W-3)'(DEPTH_WORDS);
    assign reqErr     = (bus.MemRead & bus.memWrite) | misaligned | outOfRange;

    assign execNow      = (state == BUSY) && (count == '0);
    // State is forced to IDLE asynchronously, so an aborted write never commits.
    assign arrayWriteEn = execNow && isWrite && !isErr;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk       (clk),
        .writeEn   (arrayWriteEn),
        .addr      (wordIdx),
        .writeData (writeWord),
        .readWord  (arrayWord)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            isWrite   <= 1'b0;
            isErr     <= 1'b0;
            wordIdx   <= '0;
            writeWord <= '0;
            readDataQ <= '0;
            readyQ    <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            readyQ <= 1'b0;
            errQ   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.MemRead || bus.memWrite) begin
                        isWrite   <= bus.memWrite;
                        isErr     <= reqErr;
                        wordIdx   <= bus.memadr[IDX_W+2:3];
                        writeWord <= bus.writedata;
                        count     <= CNT_W'(LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state  <= DONE;
                        readyQ <= 1'b1;
                        errQ   <= isErr;
                        if (isErr) begin
                            readDataQ <= '0;
                        end else if (!isWrite) begin
                            readDataQ <= arrayWord;
                        end
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ReadData = readDataQ;
    assign bus.memReady = readyQ;
    assign bus.memErr   = errQ;

endmodule
